// File: rtl/axis_rr_packet_mux.sv
// N:1 AXI-Stream packet multiplexer driven by an external round-robin arbiter.
// Requests are presented while idle, the one-hot grant is latched and acknowledged,
// and the egress is locked to the winner until its tlast beat has been accepted.
module axis_rr_packet_mux #(
  parameter int unsigned MASTER_NUM = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic [MASTER_NUM-1:0]            s_tvalid_i,
  output logic [MASTER_NUM-1:0]            s_tready_o,
  input  logic [MASTER_NUM*DATA_WIDTH-1:0] s_tdata_i,
  input  logic [MASTER_NUM-1:0]            s_tlast_i,
  output logic                             m_tvalid_o,
  input  logic                             m_tready_i,
  output logic [DATA_WIDTH-1:0]            m_tdata_o,
  output logic                             m_tlast_o,
  output logic [MASTER_NUM-1:0]            arb_req_o,
  input  logic [MASTER_NUM-1:0]            arb_grant_i,
  output logic                             arb_ack_o,
  output logic                             busy_o,
  output logic [$clog2(MASTER_NUM)-1:0]    sel_o
);

  localparam int unsigned SEL_WIDTH = $clog2(MASTER_NUM);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic                  r_m_tvalid;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tlast;

  logic [SEL_WIDTH-1:0]  w_grant_idx;
  logic                  w_grant_any;
  logic                  w_out_ready;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_accept;

  assign w_grant_any = |arb_grant_i;
  assign w_out_ready = !r_m_tvalid || m_tready_i;
  assign w_sel_valid = s_tvalid_i[r_sel];
  assign w_sel_last  = s_tlast_i[r_sel];
  assign w_sel_data  = s_tdata_i[r_sel*DATA_WIDTH +: DATA_WIDTH];
  assign w_accept    = (r_state == LOCK) && w_sel_valid && w_out_ready;

  // Index of the lowest set grant bit; stray grant bits are honoured the same way.
  always_comb begin
    logic w_found;
    w_grant_idx = '0;
    w_found     = 1'b0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      if (arb_grant_i[i] && !w_found) begin
        w_grant_idx = SEL_WIDTH'(i);
        w_found     = 1'b1;
      end
    end
  end

  // Next-state and handshake outputs; ack is masked while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    arb_req_o   = '0;
    arb_ack_o   = 1'b0;
    s_tready_o  = '0;
    case (r_state)
      IDLE: begin
        arb_req_o = s_tvalid_i;
        if (w_grant_any && rstn_i) begin
          arb_ack_o   = 1'b1;
          w_state_nxt = LOCK;
        end
      end
      LOCK: begin
        s_tready_o[r_sel] = w_out_ready;
        if (w_accept && w_sel_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and latched winner index.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_grant_any) begin
        r_sel <= w_grant_idx;
      end
    end
  end

  // Egress register: load on accept, drain on ready, hold while stalled.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
    end else if (w_accept) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= w_sel_data;
      r_m_tlast  <= w_sel_last;
    end else if (m_tready_i) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_tvalid_o = r_m_tvalid;
  assign m_tdata_o  = r_m_tdata;
  assign m_tlast_o  = r_m_tlast;
  assign busy_o     = (r_state == LOCK);
  assign sel_o      = r_sel;

endmodule

// File: tb/tb_axis_rr_packet_mux.sv
// Bench for axis_rr_packet_mux: per-master packet queues feed the sources, a
// round-robin arbiter model answers requests, and every egress beat is matched
// against the head packet of the source it must have come from.
module tb_axis_rr_packet_mux;

  localparam int N  = 4;
  localparam int DW = 32;
  typedef logic [DW:0] beat_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  s_tvalid, s_tready, s_tlast, arb_req, arb_grant;
  logic [N*DW-1:0] s_tdata;
  logic          m_tvalid, m_tready, m_tlast, arb_ack, busy;
  logic [DW-1:0] m_tdata;
  logic [1:0]    sel;

  always #5 clk = ~clk;

  axis_rr_packet_mux #(.MASTER_NUM(N), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .s_tdata_i(s_tdata), .s_tlast_i(s_tlast),
    .m_tvalid_o(m_tvalid), .m_tready_i(m_tready), .m_tdata_o(m_tdata), .m_tlast_o(m_tlast),
    .arb_req_o(arb_req), .arb_grant_i(arb_grant), .arb_ack_o(arb_ack),
    .busy_o(busy), .sel_o(sel)
  );

  int checks = 0, errors = 0;
  beat_t src_q[N][$];
  beat_t exp_q[N][$];
  bit    gap[N];
  int    rr_ptr = 0, ack_cnt = 0, cyc = 0, cur_m = -1, beat_idx = 0, uid = 1, pkts_added = 0;
  int    pkt_order[$], pkt_first[$], pkt_last[$], last_pos[$];
  bit    force_en = 1'b0;
  logic [N-1:0] force_grant = '0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [31:0] rnd_base(int m);
    uid++;
    return {8'(m + 1), 16'(uid), 8'h00};
  endfunction

  task automatic add_pkt(int m, int n, logic [31:0] base);
    beat_t bt;
    for (int b = 0; b < n; b++) begin
      bt = {(b == n - 1), base + 32'(b)};
      src_q[m].push_back(bt);
      exp_q[m].push_back(bt);
    end
    pkts_added++;
  endtask

  // Drive sources from their queues, then answer the settled requests with a grant.
  task automatic refresh();
    for (int m = 0; m < N; m++) begin
      if (src_q[m].size() > 0 && !gap[m]) begin
        s_tvalid[m]          = 1'b1;
        s_tdata[m*DW +: DW]  = src_q[m][0][DW-1:0];
        s_tlast[m]           = src_q[m][0][DW];
      end else begin
        s_tvalid[m]          = 1'b0;
        s_tdata[m*DW +: DW]  = $urandom;
        s_tlast[m]           = 1'($urandom_range(0, 1));
      end
    end
    #1;
    if (force_en) arb_grant = force_grant;
    else begin
      arb_grant = '0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (rr_ptr + k) % N;
        if (arb_req[idx] && arb_grant == '0) arb_grant[idx] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic egress(beat_t eb);
    if (cur_m < 0) begin
      int found;
      found = -1;
      for (int m = 0; m < N; m++)
        if (found < 0 && exp_q[m].size() > 0 && exp_q[m][0] === eb) found = m;
      chk("egress_pkt_head_known", 64'(found >= 0), 64'd1);
      if (found >= 0) begin
        cur_m = found;
        pkt_order.push_back(found);
        pkt_first.push_back(cyc);
      end
    end else begin
      chk("egress_beat", 64'(eb), exp_q[cur_m].size() > 0 ? 64'(exp_q[cur_m][0]) : '1);
    end
    if (cur_m >= 0 && exp_q[cur_m].size() > 0) void'(exp_q[cur_m].pop_front());
    beat_idx++;
    if (eb[DW]) begin
      last_pos.push_back(beat_idx);
      pkt_last.push_back(cyc);
      cur_m = -1;
    end
  endtask

  // One clock: capture pre-edge handshakes, advance the models, redrive, check invariants.
  task automatic tick();
    logic [N-1:0] hs;
    logic eg, ack, stall;
    beat_t eb;
    int gidx;
    hs = s_tvalid & s_tready;
    eg = m_tvalid && m_tready;
    ack = arb_ack;
    stall = m_tvalid && !m_tready;
    eb = {m_tlast, m_tdata};
    gidx = 0;
    for (int k = N - 1; k >= 0; k--) if (arb_grant[k]) gidx = k;
    @(posedge clk);
    #1;
    cyc++;
    if (ack) begin
      ack_cnt++;
      rr_ptr = (gidx + 1) % N;
    end
    for (int m = 0; m < N; m++) if (hs[m] && src_q[m].size() > 0) void'(src_q[m].pop_front());
    if (eg) egress(eb);
    if (stall) chk("hold_stable", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, eb}));
    refresh();
    if (m_tvalid && !m_tready) chk("stall_no_tready", 64'(s_tready), 64'd0);
    chk("tready_onehot0", 64'($countones(s_tready) <= 1), 64'd1);
  endtask

  function automatic bit all_done();
    for (int m = 0; m < N; m++) if (src_q[m].size() > 0 || exp_q[m].size() > 0) return 1'b0;
    return !busy && !m_tvalid;
  endfunction

  task automatic drain(string tag, int budget);
    int n;
    n = 0;
    while (!all_done() && n < budget) begin
      tick();
      n++;
    end
    chk({"drain_", tag}, 64'(all_done()), 64'd1);
  endtask

  task automatic clear_models();
    for (int m = 0; m < N; m++) begin
      src_q[m].delete();
      exp_q[m].delete();
      gap[m] = 1'b0;
    end
    cur_m = -1;
    force_en = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    clear_models();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    refresh();
  endtask

  initial begin
    int a0, b0, p0, pa0;
    int exp3[5];
    rstn = 1'b0; m_tready = 1'b0; s_tvalid = '0; s_tdata = '0; s_tlast = '0; arb_grant = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mvalid", 64'(m_tvalid), 64'd0);
    chk("rst_mdata", 64'(m_tdata), 64'd0);
    chk("rst_mlast", 64'(m_tlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    chk("rst_stready", 64'(s_tready), 64'd0);
    chk("rst_ack", 64'(arb_ack), 64'd0);
    rstn = 1'b1;
    refresh();

    // Reset asserted mid-packet with a beat stalled in the egress register.
    add_pkt(1, 3, 32'h1100_0000);
    refresh();
    tick();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_sel", 64'(sel), 64'd1);
    tick();
    chk("t1_mvalid", 64'(m_tvalid), 64'd1);
    chk("t1_mdata", 64'(m_tdata), 64'h1100_0000);
    tick();
    #2;
    rstn = 1'b0;
    refresh();
    chk("t1_rst_mvalid", 64'(m_tvalid), 64'd0);
    chk("t1_rst_busy", 64'(busy), 64'd0);
    chk("t1_rst_stready", 64'(s_tready), 64'd0);
    chk("t1_rst_ack", 64'(arb_ack), 64'd0);
    chk("t1_rst_sel", 64'(sel), 64'd0);
    clear_models();
    @(posedge clk);
    #1;
    chk("t1_rst_hold_idle", 64'(busy), 64'd0);
    rstn = 1'b1;
    m_tready = 1'b1;
    refresh();

    // Single master, 4-beat packet at full throughput.
    a0 = ack_cnt; b0 = beat_idx; p0 = pkt_order.size();
    add_pkt(2, 4, 32'h0000_00A0);
    refresh();
    chk("t2_ack_now", 64'(arb_ack), 64'd1);
    tick();
    chk("t2_busy", 64'(busy), 64'd1);
    chk("t2_sel", 64'(sel), 64'd2);
    drain("t2", 50);
    chk("t2_ack_count", 64'(ack_cnt - a0), 64'd1);
    chk("t2_master", 64'(qget(pkt_order, p0)), 64'd2);
    chk("t2_beats", 64'(beat_idx - b0), 64'd4);
    chk("t2_consecutive", 64'(qget(pkt_last, p0) - qget(pkt_first, p0)), 64'd3);
    chk("t2_tlast_pos", 64'(qget(last_pos, last_pos.size() - 1)), 64'(b0 + 4));

    // Round-robin order with all masters loaded; one idle cycle between packets.
    rr_ptr = 0; a0 = ack_cnt; p0 = pkt_order.size();
    add_pkt(0, 2, rnd_base(0));
    add_pkt(1, 2, rnd_base(1));
    add_pkt(2, 2, rnd_base(2));
    add_pkt(3, 2, rnd_base(3));
    add_pkt(0, 2, rnd_base(0));
    refresh();
    drain("t3", 200);
    exp3 = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_order%0d", k), 64'(qget(pkt_order, p0 + k)), 64'(exp3[k]));
      if (k > 0)
        chk($sformatf("t3_gap%0d", k),
            64'(qget(pkt_first, p0 + k) - qget(pkt_last, p0 + k - 1)), 64'd2);
    end
    chk("t3_ack_count", 64'(ack_cnt - a0), 64'd5);

    // Egress backpressure 1,0,0,1 during a 3-beat packet.
    b0 = beat_idx; a0 = ack_cnt;
    add_pkt(1, 3, rnd_base(1));
    m_tready = 1'b1;
    refresh();
    tick();
    m_tready = 1'b1; refresh(); tick();
    m_tready = 1'b0; refresh(); tick();
    m_tready = 1'b0; refresh(); tick();
    chk("t4_stalled_valid", 64'(m_tvalid), 64'd1);
    chk("t4_stalled_tready", 64'(s_tready[1]), 64'd0);
    m_tready = 1'b1; refresh(); tick();
    drain("t4", 50);
    chk("t4_beats", 64'(beat_idx - b0), 64'd3);
    chk("t4_ack_count", 64'(ack_cnt - a0), 64'd1);

    // Source gap on the locked master while another master waits.
    rr_ptr = 0; p0 = pkt_order.size();
    add_pkt(0, 5, rnd_base(0));
    add_pkt(3, 2, rnd_base(3));
    refresh();
    tick();
    tick();
    tick();
    gap[0] = 1'b1;
    refresh();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_busy", 64'(busy), 64'd1);
      chk("t5_sel", 64'(sel), 64'd0);
      chk("t5_block3", 64'(s_tready[3]), 64'd0);
    end
    gap[0] = 1'b0;
    refresh();
    drain("t5", 100);
    chk("t5_first", 64'(qget(pkt_order, p0)), 64'd0);
    chk("t5_second", 64'(qget(pkt_order, p0 + 1)), 64'd3);

    // Mixed lengths: 1-beat then 3-beat.
    rr_ptr = 0; a0 = ack_cnt; b0 = beat_idx;
    add_pkt(1, 1, rnd_base(1));
    add_pkt(2, 3, rnd_base(2));
    refresh();
    drain("t6", 100);
    chk("t6_ack_count", 64'(ack_cnt - a0), 64'd2);
    chk("t6_last1", 64'(qget(last_pos, last_pos.size() - 2)), 64'(b0 + 1));
    chk("t6_last2", 64'(qget(last_pos, last_pos.size() - 1)), 64'(b0 + 4));

    // Stray grant bits latch lowest index; grant while locked is ignored.
    force_en = 1'b1; force_grant = 4'b0110;
    refresh();
    chk("t7_req_none", 64'(arb_req), 64'd0);
    chk("t7_ack", 64'(arb_ack), 64'd1);
    tick();
    chk("t7_busy", 64'(busy), 64'd1);
    chk("t7_sel", 64'(sel), 64'd1);
    force_grant = 4'b1000;
    refresh();
    chk("t7_lock_ack", 64'(arb_ack), 64'd0);
    chk("t7_lock_req", 64'(arb_req), 64'd0);
    tick();
    chk("t7_lock_sel", 64'(sel), 64'd1);
    do_reset();
    m_tready = 1'b1;
    refresh();

    // Randomized traffic with random backpressure and source gaps.
    p0 = pkt_order.size(); pa0 = pkts_added;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        int m;
        m = $urandom_range(0, N - 1);
        if (src_q[m].size() < 8) add_pkt(m, $urandom_range(1, 4), rnd_base(m));
      end
      if ($urandom_range(0, 19) == 0) gap[$urandom_range(0, N - 1)] = 1'b1;
      for (int m = 0; m < N; m++) if (gap[m] && $urandom_range(0, 3) == 0) gap[m] = 1'b0;
      m_tready = ($urandom_range(0, 3) != 0);
      refresh();
      tick();
    end
    for (int m = 0; m < N; m++) gap[m] = 1'b0;
    m_tready = 1'b1;
    refresh();
    drain("rand", 2000);
    chk("rand_pkt_count", 64'(pkt_order.size() - p0), 64'(pkts_added - pa0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
